// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: accepts one instruction, drives operands for EXEC+WB, commits result.
// Latency 2 cycles handshake-to-commit; instr_ready low in EXEC/WB so one instruction per 3 cycles.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [19:0] instr,
  output logic        instr_ready,
  output logic        alu_enable,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags,
  input  logic [1:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [3:0]  flags,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_rf [4];
  logic [1:0]  r_rd;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [3:0]  r_op;
  logic [3:0]  r_flags;
  logic        r_done;
  logic        r_illegal;

  logic [3:0]  w_op;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs;
  logic [1:0]  w_rt;
  logic        w_imm_sel;
  logic [7:0]  w_imm;
  logic        w_unused_rsvd;
  logic        w_hs;
  logic        w_legal;

  assign w_op          = instr[19:16];
  assign w_rd          = instr[15:14];
  assign w_rs          = instr[13:12];
  assign w_rt          = instr[11:10];
  assign w_unused_rsvd = instr[9];
  assign w_imm_sel     = instr[8];
  assign w_imm         = instr[7:0];

  // Handshake decoded from state directly so it does not depend on the output mux below.
  assign w_hs    = instr_valid && (r_state == S_IDLE);
  assign w_legal = (w_op <= 4'h6);

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    alu_enable  = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (w_hs && w_legal) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_enable  = 1'b1;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        alu_enable  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rd      <= 2'd0;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_op      <= 4'h0;
      r_flags   <= 4'h0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= 8'h00;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= (r_state == S_WB);
      r_illegal <= w_hs && !w_legal;
      // Operands are captured at the handshake, so rd may alias rs/rt safely.
      if (w_hs && w_legal) begin
        r_a  <= r_rf[w_rs];
        r_b  <= w_imm_sel ? w_imm : r_rf[w_rt];
        r_op <= w_op;
        r_rd <= w_rd;
      end
      if (r_state == S_WB) begin
        r_rf[r_rd] <= alu_out;
        r_flags    <= alu_flags;
      end
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_op;
  assign rd_data    = r_rf[rd_addr];
  assign flags      = r_flags;
  assign done       = r_done;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/100ps
// Bench for alu_issue_ctrl: behavioural ALU plus a register-file/flags model driven by directed and random instructions.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [19:0] instr;
  logic        instr_ready;
  logic        alu_enable;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [3:0]  flags;
  logic        done;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_rf [4];
  logic [3:0] m_flags;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [3:0] m_op;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .alu_enable (alu_enable),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .flags      (flags),
    .done       (done),
    .illegal    (illegal)
  );

  // ALU: returns {carry, negative, zero, shift-out, out[7:0]}
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] o;
    logic       c;
    logic       so;
    int         n;
    c  = 1'b0;
    so = 1'b0;
    o  = 8'h00;
    n  = int'(b[2:0]);
    case (op)
      4'h0: begin w = {1'b0, a} + {1'b0, b}; o = w[7:0]; c = w[8]; end
      4'h1: begin w = {1'b0, a} - {1'b0, b}; o = w[7:0]; c = w[8]; end
      4'h2: o = a & b;
      4'h3: o = a | b;
      4'h4: begin o = a << n; if (n != 0) so = a[8 - n]; end
      4'h5: begin o = a >> n; if (n != 0) so = a[n - 1]; end
      4'h6: o = a ^ b;
      default: o = 8'h00;
    endcase
    return {c, o[7], (o == 8'h00), so, o};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = 12'h000;
    if (alu_enable) {alu_flags, alu_out} = alu_f(alu_opcode, alu_a, alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flags = 4'h0;
    m_a = 8'h00;
    m_b = 8'h00;
    m_op = 4'h0;
  endtask

  // Must be entered right at a negedge: four 0.2ns steps stay clear of the next posedge.
  task automatic check_rf(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #0.2;
      chk(tag, rd_data, m_rf[i]);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                     input logic [1:0] rt, input logic sel, input logic [7:0] imm);
    return {op, rd, rs, rt, 1'b0, sel, imm};
  endfunction

  // Presents w in the current IDLE cycle and follows it to completion. With hold set, nxt is
  // presented with valid high through EXEC/WB and must only be taken in the done cycle.
  task automatic issue(input logic [19:0] w, input bit hold, input logic [19:0] nxt);
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [11:0] r;
    op = w[19:16];
    rd = w[15:14];
    instr = w;
    instr_valid = 1'b1;
    chk("ready_idle", instr_ready, 1'b1);
    chk("en_idle", alu_enable, 1'b0);
    @(posedge clk);
    if (op > 4'h6) begin
      @(negedge clk);
      instr_valid = 1'b0;
      check_rf("illegal_rf");
      chk("illegal_pulse", illegal, 1'b1);
      chk("illegal_en", alu_enable, 1'b0);
      chk("illegal_ready", instr_ready, 1'b1);
      chk("illegal_flags", flags, m_flags);
      chk("illegal_a", alu_a, m_a);
      chk("illegal_b", alu_b, m_b);
      chk("illegal_op", alu_opcode, m_op);
      @(negedge clk);
      chk("illegal_clr", illegal, 1'b0);
      chk("illegal_done", done, 1'b0);
      return;
    end
    ea = m_rf[w[13:12]];
    eb = w[8] ? w[7:0] : m_rf[w[11:10]];
    m_a = ea;
    m_b = eb;
    m_op = op;
    rd_addr = rd;
    @(negedge clk);
    if (hold) instr = nxt;
    else instr_valid = 1'b0;
    chk("exec_ready", instr_ready, 1'b0);
    chk("exec_en", alu_enable, 1'b1);
    chk("exec_a", alu_a, ea);
    chk("exec_b", alu_b, eb);
    chk("exec_op", alu_opcode, op);
    chk("exec_done", done, 1'b0);
    chk("exec_illegal", illegal, 1'b0);
    chk("exec_rd_old", rd_data, m_rf[rd]);
    @(negedge clk);
    chk("wb_ready", instr_ready, 1'b0);
    chk("wb_en", alu_enable, 1'b1);
    chk("wb_a", alu_a, ea);
    chk("wb_b", alu_b, eb);
    chk("wb_rd_old", rd_data, m_rf[rd]);
    chk("wb_flags_old", flags, m_flags);
    r = alu_f(op, ea, eb);
    m_rf[rd] = r[7:0];
    m_flags = r[11:8];
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("done_ready", instr_ready, 1'b1);
    chk("done_en", alu_enable, 1'b0);
    chk("done_a_hold", alu_a, ea);
    chk("done_flags", flags, m_flags);
    chk("done_rd_new", rd_data, m_rf[rd]);
  endtask

  logic [19:0] rnd [60];

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 20'h0;
    rd_addr = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_rf("rst_rf");
    chk("rst_flags", flags, 4'h0);
    chk("rst_en", alu_enable, 1'b0);
    chk("rst_a", alu_a, 8'h00);
    chk("rst_b", alu_b, 8'h00);
    chk("rst_op", alu_opcode, 4'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1'b1);

    issue(mk(4'h3, 2'd1, 2'd0, 2'd0, 1'b1, 8'hC8), 1'b0, 20'h0);
    rd_addr = 2'd1; #0.2;
    chk("tp_or_r1", rd_data, 8'hC8);
    chk("tp_or_flags", flags, 4'b0100);
    issue(mk(4'h0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h50), 1'b0, 20'h0);
    rd_addr = 2'd2; #0.2;
    chk("tp_add_r2", rd_data, 8'h18);
    chk("tp_add_flags", flags, 4'b1000);
    issue(mk(4'h1, 2'd3, 2'd2, 2'd2, 1'b0, 8'hFF), 1'b0, 20'h0);
    rd_addr = 2'd3; #0.2;
    chk("tp_sub_r3", rd_data, 8'h00);
    chk("tp_sub_flags", flags, 4'b0010);
    issue(mk(4'h4, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01), 1'b0, 20'h0);
    rd_addr = 2'd1; #0.2;
    chk("tp_shl_r1", rd_data, 8'h90);
    chk("tp_shl_flags", flags, 4'b0101);
    issue(mk(4'h3, 2'd0, 2'd0, 2'd0, 1'b1, 8'h03), 1'b0, 20'h0);
    issue(mk(4'h5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01), 1'b0, 20'h0);
    rd_addr = 2'd0; #0.2;
    chk("tp_shr_r0", rd_data, 8'h01);
    chk("tp_shr_flags", flags, 4'b0001);

    @(negedge clk);
    issue(mk(4'h9, 2'd2, 2'd1, 2'd1, 1'b1, 8'h55), 1'b0, 20'h0);

    // Reset while the ADD targeting r2 sits in WB: no commit, no done.
    @(negedge clk);
    instr = mk(4'h0, 2'd2, 2'd2, 2'd0, 1'b1, 8'h01);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort_exec_en", alu_enable, 1'b1);
    @(negedge clk);
    chk("abort_wb_en", alu_enable, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #0.2;
    check_rf("abort_rf");
    chk("abort_flags", flags, 4'h0);
    chk("abort_en", alu_enable, 1'b0);
    chk("abort_a", alu_a, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", done, 1'b0);
    chk("abort_ready", instr_ready, 1'b1);
    chk("abort_no_illegal", illegal, 1'b0);

    // Two queued instructions with valid held high throughout.
    issue(mk(4'h3, 2'd1, 2'd0, 2'd0, 1'b1, 8'h3C), 1'b1, mk(4'h2, 2'd2, 2'd1, 2'd0, 1'b1, 8'h0F));
    issue(mk(4'h2, 2'd2, 2'd1, 2'd0, 1'b1, 8'h0F), 1'b0, 20'h0);
    rd_addr = 2'd2; #0.2;
    chk("b2b_r2", rd_data, 8'h0C);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      rnd[i] = mk(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 60; i++) begin
      bit hold;
      hold = (i < 59) && ($urandom_range(0, 1) == 1);
      issue(rnd[i], hold, (i < 59) ? rnd[i + 1] : 20'h0);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    check_rf("final_rf");
    chk("final_flags", flags, m_flags);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
